// File: rtl/junior_bit_sequencer.sv
// ---------------------------------------------------------------------------
// junior_bit_sequencer
//
// Takes a request word and hands out its set bits one at a time, lowest
// index (junior) first. Each bit that is handed out is cleared from the
// internal pending word. When the last set bit has been taken, the block
// is ready for a new word again.
//
// Handshake rules (both interfaces):
//   A transfer happens on a rising clk edge where valid=1 and ready=1.
//   valid never depends on ready. While valid=1 and ready=0, the payload
//   holds stable until the transfer happens.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous, active-high reset
//   load_valid  load_word is valid
//   load_ready  block can accept a new word (state IDLE)
//   load_word   request word to drain
//   flush       synchronous abort of the current drain (no effect in IDLE)
//   out_valid   out_index/out_onehot/out_last are valid (state DRAIN)
//   out_ready   downstream accepts the current bit
//   out_index   binary index of the current junior set bit
//   out_onehot  one-hot of the current junior set bit
//   out_last    current bit is the final set bit of the word
//   zero_o      one-cycle pulse: a loaded word was all zeros
//   busy        drain in progress (state DRAIN); doubles as the FSM state view
// ---------------------------------------------------------------------------
module junior_bit_sequencer #(
    parameter int WORD_WIDTH  = 8,
    parameter int INDEX_WIDTH = $clog2(WORD_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [WORD_WIDTH-1:0]  load_word,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic [WORD_WIDTH-1:0]  out_onehot,
    output logic                   out_last,
    output logic                   zero_o,
    output logic                   busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [WORD_WIDTH-1:0] ONE = {{(WORD_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state;
    state_t                  state_next;
    logic [WORD_WIDTH-1:0]   pending;
    logic [WORD_WIDTH-1:0]   pending_next;
    logic                    zero_next;

    logic [WORD_WIDTH-1:0]   lowest;
    logic [INDEX_WIDTH-1:0]  lowest_index;
    logic                    lowest_is_last;

    // Two's-complement trick: x & -x isolates the lowest set bit.
    assign lowest = pending & (~pending + ONE);

    // Exactly one bit set: non-zero and clearing the lowest bit leaves zero.
    assign lowest_is_last = (pending != '0) && ((pending & (pending - ONE)) == '0);

    // One-hot to binary encode; only one bit of lowest can be set.
    always_comb begin
        lowest_index = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (lowest[i]) begin
                lowest_index = lowest_index | INDEX_WIDTH'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            zero_o  <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            zero_o  <= zero_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state;
        pending_next = pending;
        zero_next    = 1'b0;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    if (load_word != '0) begin
                        pending_next = load_word;
                        state_next   = DRAIN;
                    end else begin
                        zero_next = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // flush wins over a beat presented in the same cycle.
                if (flush) begin
                    pending_next = '0;
                    state_next   = IDLE;
                end else if (out_ready) begin
                    pending_next = pending & ~lowest;
                    if (lowest_is_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                pending_next = '0;
                state_next   = IDLE;
            end
        endcase
    end

    // Output logic: everything is a function of the registered state and
    // pending word, and forced to zero outside DRAIN.
    always_comb begin
        load_ready = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        out_onehot = '0;
        out_index  = '0;
        out_last   = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
            end
            DRAIN: begin
                out_valid  = 1'b1;
                busy       = 1'b1;
                out_onehot = lowest;
                out_index  = lowest_index;
                out_last   = lowest_is_last;
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_junior_bit_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for junior_bit_sequencer (WORD_WIDTH=8).
// Expected beats ({last, index}) are queued when a word is accepted and
// popped by a monitor on each observed beat.
// ---------------------------------------------------------------------------
module tb_junior_bit_sequencer;

    localparam int W  = 8;
    localparam int IW = $clog2(W);

    // -------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [W-1:0]  load_word  = '0;
    logic          flush      = 1'b0;
    logic          out_valid;
    logic          out_ready  = 1'b0;
    logic [IW-1:0] out_index;
    logic [W-1:0]  out_onehot;
    logic          out_last;
    logic          zero_o;
    logic          busy;

    junior_bit_sequencer #(.WORD_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_word  (load_word),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_onehot (out_onehot),
        .out_last   (out_last),
        .zero_o     (zero_o),
        .busy       (busy)
    );

    // -------------------------------------------------------------- scoreboard
    logic [IW:0] exp_q[$];   // {last, index}
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Queue the expected beats of a word, junior bit first.
    task automatic push_word(input logic [W-1:0] w);
        int hi;
        hi = -1;
        for (int i = 0; i < W; i++) if (w[i]) hi = i;
        for (int i = 0; i < W; i++) begin
            if (w[i]) exp_q.push_back({(i == hi), IW'(i)});
        end
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        logic [IW:0] e;
        if (!rst) begin
            if (!out_valid) begin
                check("idle_onehot_zero", out_onehot, 0);
            end else if (out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_index", out_index, e[IW-1:0]);
                    check("beat_onehot", out_onehot, 32'(1) << e[IW-1:0]);
                    check("beat_last", out_last, e[IW]);
                end
            end
        end
    end

    // -------------------------------------------------------------- drivers
    // Present a word once load_ready is seen, hold for one edge.
    task automatic load(input logic [W-1:0] w);
        int n;
        n = 0;
        while (!load_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("load_ready_timeout", load_ready, 1);
        load_valid = 1'b1;
        load_word  = w;
        if (w != '0) push_word(w);
        @(posedge clk); #1;
        load_valid = 1'b0;
        load_word  = '0;
    endtask

    // Wait for the drain to finish; optionally randomise out_ready each cycle.
    task automatic wait_idle(input bit rand_ready);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1; n++;
        end
        out_ready = 1'b1;
        check("drain_timeout", (n < 200), 1);
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        // Reset state
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_zero", zero_o, 0);
        check("rst_onehot", out_onehot, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_load_ready", load_ready, 1);

        // 1: 1010_0100 -> 2,5,7 back to back, load_ready after last beat
        out_ready = 1'b1;
        load(8'b1010_0100);
        check("t1_first_valid", out_valid, 1);
        check("t1_first_index", out_index, 2);
        repeat (3) @(posedge clk);
        #1;
        check("t1_load_ready_back", load_ready, 1);
        check("t1_busy_low", busy, 0);
        check("t1_queue_empty", exp_q.size(), 0);

        // 2: all-zero word -> zero_o pulse, no beat
        load(8'h00);
        check("t2_zero_pulse", zero_o, 1);
        check("t2_no_valid", out_valid, 0);
        check("t2_load_ready", load_ready, 1);
        @(posedge clk); #1;
        check("t2_zero_one_cycle", zero_o, 0);

        // 3: backpressure holds index 0 stable for 3 cycles
        out_ready = 1'b0;
        load(8'b1000_0001);
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_index", out_index, 0);
            check("t3_hold_last", out_last, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_idle(1'b0);

        // 4: 0xFF flushed after three beats, then 0x10
        load(8'hFF);
        repeat (3) @(posedge clk);
        #1;
        check("t4_pre_flush_index", out_index, 3);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        check("t4_flush_valid", out_valid, 0);
        check("t4_flush_busy", busy, 0);
        check("t4_flush_ready", load_ready, 1);
        load(8'h10);
        check("t4_after_index", out_index, 4);
        check("t4_after_last", out_last, 1);
        wait_idle(1'b0);

        // 5: async reset during the first beat
        load(8'b0110_0000);
        #1 rst = 1'b1;
        #1;
        exp_q.delete();
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_onehot", out_onehot, 0);
        check("t5_rst_index", out_index, 0);
        check("t5_rst_last", out_last, 0);
        check("t5_rst_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;
        check("t5_release_ready", load_ready, 1);
        repeat (2) begin
            @(posedge clk); #1;
            check("t5_stays_empty", out_valid, 0);
        end

        // 6: load_valid held in DRAIN is ignored until the drain completes
        load(8'h05);
        load_valid = 1'b1;
        load_word  = 8'h80;
        begin
            int n;
            n = 0;
            while (!load_ready && n < 50) begin
                check("t6_held_ignored", busy, 1);
                @(posedge clk); #1; n++;
            end
            check("t6_reload_seen", load_ready, 1);
        end
        check("t6_first_drained", exp_q.size(), 0);
        push_word(8'h80);
        @(posedge clk); #1;
        load_valid = 1'b0;
        load_word  = '0;
        check("t6_second_index", out_index, 7);
        wait_idle(1'b0);

        // 7: random words with random backpressure
        for (int k = 0; k < 8; k++) begin
            load(W'($urandom_range(1, 255)));
            wait_idle(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
